// File: rtl/pe_pooling_pkg.sv
// ---------------------------------------------------------------------------
// pe_pooling_pkg
// Shared types and helpers for the pooling front-end (window generator).
//   pool_win_state_e : window generator FSM states
//   windows_per_row  : number of complete windows that fit in one row
//   cnt_width        : counter width for a 0..n-1 counter (never below 1 bit)
// ---------------------------------------------------------------------------
package pe_pooling_pkg;

   typedef enum logic {ST_FILL, ST_RUN} pool_win_state_e;

   // Windows are only emitted when fully inside the row, so any tail shorter
   // than a stride is simply dropped by the integer division.
   function automatic int windows_per_row(input int line_w, input int win_w, input int stride);
      return (line_w - win_w) / stride + 1;
   endfunction

   // A counter that only ever holds 0 still needs a 1-bit register.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pe_pooling_window_gen_if.sv
// ---------------------------------------------------------------------------
// pe_pooling_window_gen_if
// Pixel-in / window-out bundle of the pooling window generator.
//   in_valid  : pixel present (master -> block)
//   in_ready  : block can take a pixel (block -> master)
//   in_data   : pixel, pDATA_WIDTH bits
//   out_valid : one-cycle pulse per window, feeds the pooling datapath enable
//   out_data  : packed window, slice 0 (LSBs) is the oldest pixel
//   out_last  : qualifies out_valid, last window of the current row
// ---------------------------------------------------------------------------
interface pe_pooling_window_gen_if #(
   parameter int pDATA_WIDTH  = 8,
   parameter int pWINDOW_SIZE = 3
);

   logic                                in_valid;
   logic                                in_ready;
   logic [pDATA_WIDTH-1:0]              in_data;
   logic                                out_valid;
   logic [pDATA_WIDTH*pWINDOW_SIZE-1:0] out_data;
   logic                                out_last;

   modport master (
      output in_valid, in_data,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, out_valid, out_data, out_last
   );

endinterface

// File: rtl/pe_window_shreg.sv
// ---------------------------------------------------------------------------
// pe_window_shreg
// Window-wide shift register. On load the contents move one slice toward
// slice 0 and din enters the top slice.
//   clk         : clock
//   rst         : synchronous active-high reset
//   clr         : synchronous clear
//   load        : shift in din this cycle
//   din         : incoming pixel
//   window_next : contents as they will be after this cycle's load, so the
//                 owner can register a window that includes the newest pixel
// ---------------------------------------------------------------------------
module pe_window_shreg #(
   parameter int pDATA_WIDTH  = 8,
   parameter int pWINDOW_SIZE = 3
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                clr,
   input  logic                                load,
   input  logic [pDATA_WIDTH-1:0]              din,
   output logic [pDATA_WIDTH*pWINDOW_SIZE-1:0] window_next
);

   localparam int TOTAL_W = pDATA_WIDTH * pWINDOW_SIZE;

   logic [TOTAL_W-1:0] win_q;

   // Next-contents view; a one-pixel window degenerates to a plain register.
   generate
      if (pWINDOW_SIZE == 1) begin : g_single
         assign window_next = load ? din : win_q;
      end else begin : g_multi
         assign window_next = load ? {din, win_q[TOTAL_W-1:pDATA_WIDTH]} : win_q;
      end
   endgenerate

   // Storage, wiped by either reset or a stream restart.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         win_q <= '0;
      end else begin
         win_q <= window_next;
      end
   end

endmodule

// File: rtl/pe_pooling_window_gen.sv
// ---------------------------------------------------------------------------
// pe_pooling_window_gen
// Turns a raster pixel stream into 1-D pooling windows of pWINDOW_SIZE pixels
// stepped by pWINDOW_STRIDE, never spanning a row of pLINE_WIDTH pixels.
//   clk : clock
//   rst : synchronous active-high reset
//   clr : synchronous row/stream restart (in_ready unaffected)
//   io  : pe_pooling_window_gen_if.slave
//         in_valid/in_ready/in_data pixel input,
//         out_valid/out_data/out_last registered window output
// ---------------------------------------------------------------------------
module pe_pooling_window_gen
   import pe_pooling_pkg::*;
#(
   parameter int pDATA_WIDTH    = 8,
   parameter int pWINDOW_SIZE   = 3,
   parameter int pWINDOW_STRIDE = 2,
   parameter int pLINE_WIDTH    = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   pe_pooling_window_gen_if.slave  io
);

   // Refuse to build a generator whose window cannot fit in a row.
   generate
      if (pDATA_WIDTH < 1 || pWINDOW_SIZE < 1 || pWINDOW_STRIDE < 1 ||
          pLINE_WIDTH < pWINDOW_SIZE) begin : g_param_check
         $fatal(1, "pe_pooling_window_gen: illegal window/stride/line parameters");
      end
   endgenerate

   localparam int CW  = cnt_width(pLINE_WIDTH);
   localparam int SW  = cnt_width(pWINDOW_STRIDE);
   localparam int WPR = windows_per_row(pLINE_WIDTH, pWINDOW_SIZE, pWINDOW_STRIDE);

   // Column of the pixel that completes the first window, ends the row, and
   // completes the last window of the row.
   localparam logic [CW-1:0] COL_FILL_DONE = CW'(pWINDOW_SIZE - 1);
   localparam logic [CW-1:0] COL_ROW_END   = CW'(pLINE_WIDTH - 1);
   localparam logic [CW-1:0] COL_LAST_WIN  = CW'((WPR - 1) * pWINDOW_STRIDE + pWINDOW_SIZE - 1);
   localparam logic [SW-1:0] STRIDE_DONE   = SW'(pWINDOW_STRIDE - 1);

   pool_win_state_e                     state_q, state_n;
   logic [CW-1:0]                       col_q, col_n;
   logic [SW-1:0]                       stride_q, stride_n;
   logic                                emit, emit_last;
   logic                                accept, load;
   logic                                rst_q;
   logic [pDATA_WIDTH*pWINDOW_SIZE-1:0] window_next;

   assign accept = io.in_valid & io.in_ready;
   assign load   = accept & ~clr;

   pe_window_shreg #(
      .pDATA_WIDTH  (pDATA_WIDTH),
      .pWINDOW_SIZE (pWINDOW_SIZE)
   ) u_shreg (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr),
      .load        (load),
      .din         (io.in_data),
      .window_next (window_next)
   );

   // FSM and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_FILL;
         col_q    <= '0;
         stride_q <= '0;
      end else begin
         state_q  <= state_n;
         col_q    <= col_n;
         stride_q <= stride_n;
      end
   end

   // Next state and window emission. A restart beats a simultaneous pixel.
   // The row-end check comes last so it overrides the fill->run step when a
   // window spans the whole row, and every row restarts in fill.
   always_comb begin
      state_n   = state_q;
      col_n     = col_q;
      stride_n  = stride_q;
      emit      = 1'b0;
      emit_last = 1'b0;
      if (clr) begin
         state_n  = ST_FILL;
         col_n    = '0;
         stride_n = '0;
      end else if (accept) begin
         col_n = (col_q == COL_ROW_END) ? '0 : col_q + CW'(1);
         case (state_q)
            ST_FILL: begin
               if (col_q == COL_FILL_DONE) begin
                  emit     = 1'b1;
                  stride_n = '0;
                  state_n  = ST_RUN;
               end
            end
            ST_RUN: begin
               if (stride_q == STRIDE_DONE) begin
                  emit     = 1'b1;
                  stride_n = '0;
               end else begin
                  stride_n = stride_q + SW'(1);
               end
            end
         endcase
         if (col_q == COL_ROW_END) begin
            state_n  = ST_FILL;
            stride_n = '0;
         end
         emit_last = emit && (col_q == COL_LAST_WIN);
      end
   end

   // Registered outputs. rst_q stretches in_ready low one cycle past reset;
   // out_data keeps the previous window between pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         rst_q        <= 1'b1;
         io.in_ready  <= 1'b0;
         io.out_valid <= 1'b0;
         io.out_last  <= 1'b0;
         io.out_data  <= '0;
      end else begin
         rst_q        <= 1'b0;
         io.in_ready  <= ~rst_q;
         io.out_valid <= emit;
         io.out_last  <= emit_last;
         if (emit) begin
            io.out_data <= window_next;
         end
      end
   end

endmodule
